// File: rtl/block_frame_writer_if.sv
// Coordinate/pixel/RAM-write bundle between block_frame_writer (master) and
// the graphics controller plus block frame RAMs (slave).
interface block_frame_writer_if #(
  parameter int COORD_BITS = 10,
  parameter int PIXEL_BITS = 8,
  parameter int ADDR_BITS  = 10
);
  logic [COORD_BITS-1:0] x_coord_of_current_block;
  logic [COORD_BITS-1:0] y_coord_of_current_block;
  logic [PIXEL_BITS-1:0] pixel_in;
  logic                  wr_en;
  logic                  wr_bank;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [PIXEL_BITS-1:0] wr_data;

  modport master (
    output x_coord_of_current_block,
    output y_coord_of_current_block,
    input  pixel_in,
    output wr_en,
    output wr_bank,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  x_coord_of_current_block,
    input  y_coord_of_current_block,
    output pixel_in,
    input  wr_en,
    input  wr_bank,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/block_frame_writer.sv
// Block-grid scanner writing one frame of pixels into the back bank of a
// ping-pong RAM pair. Optional macro BLOCK_FRAME_WRITER_OVERRUN_CNT_EN adds overrun_count.
module block_frame_writer #(
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 24,
  parameter int COORD_BITS = 10,
  parameter int PIXEL_BITS = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  block_frame_writer_if.master  bus,
  output logic                  whichRAM,
  output logic                  busy,
  output logic                  frame_done
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrun_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    SWAP
  } state_t;

  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(GRID_W - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(GRID_H - 1);

  state_t                state_q, state_d;
  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic [ADDR_BITS-1:0]  lin_q, lin_d;
  logic                  pending_q, pending_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_BITS-1:0] wr_data_q, wr_data_d;
  logic                  which_q, which_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
  logic [7:0]            ovr_q, ovr_d;
  logic                  tick_dropped;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    lin_d        = lin_q;
    pending_d    = pending_q;
    wr_en_d      = 1'b0;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    which_d      = which_q;
    frame_done_d = 1'b0;

    // A tick arriving while busy queues exactly one frame; later ones are lost.
    if (state_q != IDLE && frame_tick && !pending_q) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = lin_q;
        wr_data_d = bus.pixel_in;
        wr_bank_d = ~which_q;
        lin_d     = lin_q + ADDR_BITS'(1);
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            lin_d   = '0;
            state_d = FLUSH;
          end else begin
            y_d = y_q + COORD_BITS'(1);
          end
        end else begin
          x_d = x_q + COORD_BITS'(1);
        end
      end
      FLUSH: begin
        state_d      = SWAP;
        which_d      = ~which_q;
        frame_done_d = 1'b1;
      end
      SWAP: begin
        // A queued frame consumes pending; a fresh tick here with nothing
        // queued starts the next frame directly instead of stranding pending.
        if (pending_q) begin
          state_d   = SCAN;
          pending_d = 1'b0;
        end else if (frame_tick) begin
          state_d   = SCAN;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
  always_comb begin
    tick_dropped = frame_tick && (state_q != IDLE) && pending_q;
    ovr_d        = ovr_q;
    if (tick_dropped && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      lin_q        <= '0;
      pending_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b1;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      which_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
      ovr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      lin_q        <= lin_d;
      pending_q    <= pending_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      which_q      <= which_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
      ovr_q        <= ovr_d;
`endif
    end
  end

  assign bus.x_coord_of_current_block = x_q;
  assign bus.y_coord_of_current_block = y_q;
  assign bus.wr_en                    = wr_en_q;
  assign bus.wr_bank                  = wr_bank_q;
  assign bus.wr_addr                  = wr_addr_q;
  assign bus.wr_data                  = wr_data_q;
  assign whichRAM                     = which_q;
  assign busy                         = busy_q;
  assign frame_done                   = frame_done_q;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
  assign overrun_count                = ovr_q;
`endif

endmodule

// File: tb/tb_block_frame_writer.sv
// Scoreboard bench for block_frame_writer: a 32x24 instance for frame/overrun/reset
// scenarios and a 4x3 instance for exact cycle timing.
module tb_block_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic frame_tick;
  logic whichRAM, busy, frame_done;
  logic s_frame_tick;
  logic s_whichRAM, s_busy, s_frame_done;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
  logic [7:0] s_overrun_count;
`endif

  block_frame_writer_if #(.COORD_BITS(10), .PIXEL_BITS(8), .ADDR_BITS(10)) bus ();
  block_frame_writer_if #(.COORD_BITS(10), .PIXEL_BITS(8), .ADDR_BITS(4))  s_bus ();

  // Pixel source: (y*32+x) & 0xFF for the big grid, {y,x} ^ 0xA5 for the small grid.
  logic [9:0] m_lin;
  assign m_lin = (bus.y_coord_of_current_block << 5) + bus.x_coord_of_current_block;
  assign bus.pixel_in = m_lin[7:0];
  assign s_bus.pixel_in = {s_bus.y_coord_of_current_block[3:0],
                           s_bus.x_coord_of_current_block[3:0]} ^ 8'hA5;

  block_frame_writer #(
    .GRID_W(32), .GRID_H(24), .COORD_BITS(10), .PIXEL_BITS(8), .ADDR_BITS(10)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .bus(bus),
    .whichRAM(whichRAM), .busy(busy), .frame_done(frame_done)
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
    , .overrun_count(overrun_count)
`endif
  );

  block_frame_writer #(
    .GRID_W(4), .GRID_H(3), .COORD_BITS(10), .PIXEL_BITS(8), .ADDR_BITS(4)
  ) s_dut (
    .clk(clk), .reset(reset), .frame_tick(s_frame_tick), .bus(s_bus),
    .whichRAM(s_whichRAM), .busy(s_busy), .frame_done(s_frame_done)
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
    , .overrun_count(s_overrun_count)
`endif
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       bank;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Scoreboard consumer: every write of the big instance must match the queue head.
  always @(negedge clk) begin
    wr_t e;
    wr_t got;
    if (reset && bus.wr_en) begin
      got = {bus.wr_addr, bus.wr_data, bus.wr_bank};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%0h bank=%0d, required no write",
                 bus.wr_addr, bus.wr_data, bus.wr_bank);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL write: got addr=%0d data=%0h bank=%0d, required addr=%0d data=%0h bank=%0d",
                   got.addr, got.data, got.bank, e.addr, e.data, e.bank);
        else
          n_pass++;
      end
    end
  end

  task automatic push_frame(input logic bank);
    for (int i = 0; i < 768; i++) begin
      exp_q.push_back({10'(i), 8'(i & 255), bank});
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int writes, output bit consec, output bit tmo);
    bit seen, gap;
    writes = 0; seen = 0; gap = 0; tmo = 1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (frame_done) begin
        tmo = 0;
        break;
      end
      if (bus.wr_en) begin
        writes++;
        seen = 1;
      end else if (seen) begin
        gap = 1;
      end
    end
    consec = !gap;
  endtask

  task automatic wait_addr(input logic [9:0] addr, input int limit, output bit tmo);
    tmo = 1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.wr_en && bus.wr_addr == addr) begin
        tmo = 0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.wr_en, busy, frame_done} !== 3'b000)
        $display("FAIL idle_quiet: got wr_en/busy/done=%b, required 000", {bus.wr_en, busy, frame_done});
      else n_pass++;
    end
    n_checks++;
    if ({bus.x_coord_of_current_block, bus.y_coord_of_current_block} !== 20'd0)
      $display("FAIL reset_coords: got %0d,%0d required 0,0",
               bus.x_coord_of_current_block, bus.y_coord_of_current_block);
    else n_pass++;
    n_checks++;
    if ({bus.wr_addr, bus.wr_data} !== 18'd0)
      $display("FAIL reset_wr: got addr=%0d data=%0h required 0,0", bus.wr_addr, bus.wr_data);
    else n_pass++;
    n_checks++;
    if ({bus.wr_bank, whichRAM} !== 2'b10)
      $display("FAIL reset_banks: got wr_bank/whichRAM=%b required 10", {bus.wr_bank, whichRAM});
    else n_pass++;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
    n_checks++;
    if (overrun_count !== 8'd0)
      $display("FAIL reset_overrun: got %0d required 0", overrun_count);
    else n_pass++;
`endif
  endtask

  task automatic test_small_grid();
    int wx, wy, px, py;
    logic [7:0] wd;
    s_frame_tick = 1'b1;
    @(negedge clk);
    s_frame_tick = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      wx = (k <= 12) ? (k - 1) % 4 : 0;
      wy = (k <= 12) ? (k - 1) / 4 : 0;
      n_checks++;
      if (s_bus.x_coord_of_current_block !== 10'(wx) || s_bus.y_coord_of_current_block !== 10'(wy))
        $display("FAIL small_coord k=%0d: got %0d,%0d required %0d,%0d", k,
                 s_bus.x_coord_of_current_block, s_bus.y_coord_of_current_block, wx, wy);
      else n_pass++;
      n_checks++;
      if ({s_busy, s_frame_done, s_whichRAM} !== {k <= 14, k == 14, k >= 14})
        $display("FAIL small_ctrl k=%0d: got busy/done/which=%b required %b", k,
                 {s_busy, s_frame_done, s_whichRAM}, {k <= 14, k == 14, k >= 14});
      else n_pass++;
      n_checks++;
      if (s_bus.wr_en !== (k >= 2 && k <= 13))
        $display("FAIL small_wr_en k=%0d: got %b required %b", k, s_bus.wr_en, (k >= 2 && k <= 13));
      else n_pass++;
      if (k >= 2 && k <= 13) begin
        px = (k - 2) % 4;
        py = (k - 2) / 4;
        wd = {4'(py), 4'(px)} ^ 8'hA5;
        n_checks++;
        if (s_bus.wr_addr !== 4'(k - 2) || s_bus.wr_data !== wd || s_bus.wr_bank !== 1'b1)
          $display("FAIL small_write k=%0d: got addr=%0d data=%0h bank=%0d required addr=%0d data=%0h bank=1",
                   k, s_bus.wr_addr, s_bus.wr_data, s_bus.wr_bank, k - 2, wd);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_frame();
    int writes;
    bit consec, tmo;
    push_frame(1'b1);
    pulse_tick();
    wait_done(2000, writes, consec, tmo);
    n_checks++;
    if (tmo) $display("FAIL single_done_timeout: got no frame_done, required one");
    else n_pass++;
    n_checks++;
    if (writes != 768 || !consec)
      $display("FAIL single_writes: got %0d writes consecutive=%0d, required 768 consecutive=1", writes, consec);
    else n_pass++;
    n_checks++;
    if (whichRAM !== 1'b1) $display("FAIL single_swap: got whichRAM=%b required 1", whichRAM);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, bus.wr_en} !== 3'b000)
      $display("FAIL single_idle: got busy/done/wr_en=%b required 000", {busy, frame_done, bus.wr_en});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int writes;
    bit consec, tmo;
    push_frame(1'b0);
    pulse_tick();
    wait_addr(10'd300, 2000, tmo);
    n_checks++;
    if (tmo) $display("FAIL b2b_addr_timeout: got no write at addr 300, required one");
    else n_pass++;
    push_frame(1'b1);
    pulse_tick();
    wait_done(2000, writes, consec, tmo);
    n_checks++;
    if (tmo || whichRAM !== 1'b0)
      $display("FAIL b2b_first_swap: got timeout=%0d whichRAM=%b required 0,0", tmo, whichRAM);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, frame_done, bus.wr_en} !== 3'b100 ||
        {bus.x_coord_of_current_block, bus.y_coord_of_current_block} !== 20'd0)
      $display("FAIL b2b_restart: got busy/done/wr_en=%b x=%0d y=%0d required 100 x=0 y=0",
               {busy, frame_done, bus.wr_en}, bus.x_coord_of_current_block, bus.y_coord_of_current_block);
    else n_pass++;
    wait_done(2000, writes, consec, tmo);
    n_checks++;
    if (tmo || writes != 768 || whichRAM !== 1'b1)
      $display("FAIL b2b_second: got timeout=%0d writes=%0d whichRAM=%b required 0,768,1", tmo, writes, whichRAM);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int writes;
    bit consec, tmo;
    push_frame(1'b0);
    pulse_tick();
    wait_addr(10'd100, 2000, tmo);
    n_checks++;
    if (tmo) $display("FAIL ovr_addr_timeout: got no write at addr 100, required one");
    else n_pass++;
    push_frame(1'b1);
    pulse_tick();
    repeat (5) @(negedge clk);
    pulse_tick();
    wait_done(2000, writes, consec, tmo);
    wait_done(2000, writes, consec, tmo);
    n_checks++;
    if (tmo || writes != 768 || whichRAM !== 1'b1)
      $display("FAIL ovr_frames: got timeout=%0d writes=%0d whichRAM=%b required 0,768,1", tmo, writes, whichRAM);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL ovr_no_third: got busy=%b required 0", busy);
      else n_pass++;
    end
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
    n_checks++;
    if (overrun_count !== 8'd1) $display("FAIL ovr_count: got %0d required 1", overrun_count);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_frame();
    int writes;
    bit consec, tmo;
    apply_reset();
    @(negedge clk);
    push_frame(1'b1);
    pulse_tick();
    wait_addr(10'd100, 2000, tmo);
    n_checks++;
    if (tmo) $display("FAIL mid_addr_timeout: got no write at addr 100, required one");
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.wr_en, busy, whichRAM} !== 3'b000 ||
        {bus.x_coord_of_current_block, bus.y_coord_of_current_block, bus.wr_addr} !== 30'd0)
      $display("FAIL mid_reset_async: got wr_en/busy/which=%b x=%0d y=%0d addr=%0d required 000 0 0 0",
               {bus.wr_en, busy, whichRAM}, bus.x_coord_of_current_block,
               bus.y_coord_of_current_block, bus.wr_addr);
    else n_pass++;
`ifdef BLOCK_FRAME_WRITER_OVERRUN_CNT_EN
    n_checks++;
    if (overrun_count !== 8'd0) $display("FAIL mid_overrun_clear: got %0d required 0", overrun_count);
    else n_pass++;
`endif
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_frame(1'b1);
    pulse_tick();
    wait_done(2000, writes, consec, tmo);
    n_checks++;
    if (tmo || writes != 768 || !consec || whichRAM !== 1'b1)
      $display("FAIL mid_restart: got timeout=%0d writes=%0d consec=%0d whichRAM=%b required 0,768,1,1",
               tmo, writes, consec, whichRAM);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    frame_tick = 1'b0;
    s_frame_tick = 1'b0;
    @(negedge clk);
    test_reset();
    test_small_grid();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending writes required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
